fifo_hub: RTL and testbench

// - Parametrised, single-clock successor to the multi-stream FIFO bank. Holds CHANNELS independent FIFOs.
// - Each channel accepts IN_W-bit sensor words and returns them as OUT_W-bit slices, most-significant slice first.
// - Sits between the sensor capture logic and the Bluetooth UART packetiser.
// - Adds a per-channel almost-full flag and selectable storage depth.

---
 rtl/fifo_hub.sv | 144 ++++++++++++++
 tb/tb_fifo_hub.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_hub.sv
// rtl/fifo_hub.sv - bank of independent FIFOs, IN_W-bit words in, OUT_W-bit slices out (MS slice first)
// Optional sticky overflow/underflow flags: define FIFO_HUB_ERR_FLAGS_EN.
module fifo_hub #(
  parameter int CHANNELS  = 8,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 1024,
  parameter int AF_THRESH = 1020,
  localparam int RATIO    = IN_W / OUT_W,
  localparam int AW       = $clog2(DEPTH),
  localparam int SW       = $clog2(RATIO)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [CHANNELS*IN_W-1:0]        din,
  input  logic [CHANNELS-1:0]             write_enable,
  input  logic [CHANNELS-1:0]             read_enable,
  output logic [CHANNELS*OUT_W-1:0]       dout,
  output logic [CHANNELS-1:0]             full_flag,
  output logic [CHANNELS-1:0]             empty_flag,
  output logic [CHANNELS-1:0]             almost_full_flag,
  output logic [CHANNELS*(AW+1)-1:0]      wr_count,
  output logic [CHANNELS*(AW+SW+1)-1:0]   rd_count
`ifdef FIFO_HUB_ERR_FLAGS_EN
  ,
  output logic [CHANNELS-1:0]             error_flag
`endif
);

  localparam int KW = (SW > 0) ? SW : 1;
  localparam int CW = AW + 1;
  localparam int RW = AW + SW + 1;

  logic [IN_W-1:0]  mem [CHANNELS][DEPTH];

  logic [AW-1:0]    wr_ptr    [CHANNELS];
  logic [AW-1:0]    rd_ptr    [CHANNELS];
  logic [KW-1:0]    slice_idx [CHANNELS];
  logic [CW-1:0]    count     [CHANNELS];
  logic [OUT_W-1:0] dout_q    [CHANNELS];
  logic [OUT_W-1:0] head_slice [CHANNELS];

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] wr_ok;
  logic [CHANNELS-1:0] rd_ok;
  logic [CHANNELS-1:0] pop;

  // Flags come straight from the registered word count; a partially read
  // head word still counts, so word count 0 also means slice count 0.
  always_comb begin
    full  = '0;
    empty = '0;
    wr_ok = '0;
    rd_ok = '0;
    pop   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]  = (count[c] == CW'(DEPTH));
      empty[c] = (count[c] == '0);
      wr_ok[c] = write_enable[c] & ~full[c];
      rd_ok[c] = read_enable[c] & ~empty[c];
      pop[c]   = rd_ok[c] & (slice_idx[c] == KW'(RATIO - 1));
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      head_slice[c] = '0;
      head_slice[c] = mem[c][rd_ptr[c]][IN_W - 1 - int'(slice_idx[c]) * OUT_W -: OUT_W];
    end
  end

  // Storage is never reset so it can map onto block RAM.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_ok[c]) begin
        mem[c][wr_ptr[c]] <= din[c*IN_W +: IN_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c]    <= '0;
        rd_ptr[c]    <= '0;
        slice_idx[c] <= '0;
        count[c]     <= '0;
        dout_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_ok[c]) begin
          wr_ptr[c] <= wr_ptr[c] + AW'(1);
        end
        if (rd_ok[c]) begin
          dout_q[c] <= head_slice[c];
          if (pop[c]) begin
            slice_idx[c] <= '0;
            rd_ptr[c]    <= rd_ptr[c] + AW'(1);
          end else begin
            slice_idx[c] <= slice_idx[c] + KW'(1);
          end
        end
        case ({wr_ok[c], pop[c]})
          2'b10:   count[c] <= count[c] + CW'(1);
          2'b01:   count[c] <= count[c] - CW'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  always_comb begin
    dout             = '0;
    wr_count         = '0;
    rd_count         = '0;
    almost_full_flag = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      dout[c*OUT_W +: OUT_W] = dout_q[c];
      wr_count[c*CW +: CW]   = count[c];
      rd_count[c*RW +: RW]   = (RW'(count[c]) << SW) - RW'(slice_idx[c]);
      almost_full_flag[c]    = (count[c] >= CW'(AF_THRESH));
    end
  end

  assign full_flag  = full;
  assign empty_flag = empty;

`ifdef FIFO_HUB_ERR_FLAGS_EN
  logic [CHANNELS-1:0] err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | (write_enable & full) | (read_enable & empty);
    end
  end

  assign error_flag = err_q;
`endif

endmodule

// File: tb/tb_fifo_hub.sv
// tb/tb_fifo_hub.sv - directed self-checking bench for fifo_hub (default parameters)
module tb_fifo_hub;

  localparam int CH = 8;
  localparam int IW = 16;
  localparam int OW = 8;
  localparam int CW = 11;
  localparam int RW = 12;

  logic              clock;
  logic              reset;
  logic [CH*IW-1:0]  din;
  logic [CH-1:0]     write_enable;
  logic [CH-1:0]     read_enable;
  logic [CH*OW-1:0]  dout;
  logic [CH-1:0]     full_flag;
  logic [CH-1:0]     empty_flag;
  logic [CH-1:0]     almost_full_flag;
  logic [CH*CW-1:0]  wr_count;
  logic [CH*RW-1:0]  rd_count;
`ifdef FIFO_HUB_ERR_FLAGS_EN
  logic [CH-1:0]     error_flag;
`endif

  int checks = 0;
  int errors = 0;

  fifo_hub dut (
    .clock            (clock),
    .reset            (reset),
    .din              (din),
    .write_enable     (write_enable),
    .read_enable      (read_enable),
    .dout             (dout),
    .full_flag        (full_flag),
    .empty_flag       (empty_flag),
    .almost_full_flag (almost_full_flag),
    .wr_count         (wr_count),
    .rd_count         (rd_count)
`ifdef FIFO_HUB_ERR_FLAGS_EN
    ,
    .error_flag       (error_flag)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_din(input int c, input logic [IW-1:0] v);
    din[c*IW +: IW] = v;
  endtask

  function automatic logic [CW-1:0] wc(input int c);
    return wr_count[c*CW +: CW];
  endfunction

  function automatic logic [RW-1:0] rc(input int c);
    return rd_count[c*RW +: RW];
  endfunction

  function automatic logic [OW-1:0] dq(input int c);
    return dout[c*OW +: OW];
  endfunction

  initial begin
    logic [IW-1:0] w;
    logic [OW-1:0] exp_slice;

    reset        = 1'b0;
    din          = '0;
    write_enable = '0;
    read_enable  = '0;
    repeat (2) tick();

    check("rst_wr_count", wr_count, '0);
    check("rst_rd_count", rd_count, '0);
    check("rst_empty", empty_flag, 8'hFF);
    check("rst_full", full_flag, 8'h00);
    check("rst_af", almost_full_flag, 8'h00);
    check("rst_dout", dout, '0);

    reset = 1'b1;
    tick();

    // ch0: one word, two slices, MS first
    set_din(0, 16'h4869);
    write_enable[0] = 1'b1;
    tick();
    write_enable[0] = 1'b0;
    check("ch0_wc_after_wr", wc(0), 11'd1);
    check("ch0_rc_after_wr", rc(0), 12'd2);
    check("ch0_empty_after_wr", empty_flag[0], 1'b0);

    read_enable[0] = 1'b1;
    tick();
    check("ch0_slice0", dq(0), 8'h48);
    check("ch0_rc_mid", rc(0), 12'd1);
    check("ch0_wc_mid", wc(0), 11'd1);
    tick();
    check("ch0_slice1", dq(0), 8'h69);
    check("ch0_empty_end", empty_flag[0], 1'b1);
    check("ch0_wc_end", wc(0), 11'd0);
    tick();
    read_enable[0] = 1'b0;
    check("ch0_dout_hold", dq(0), 8'h69);
    check("ch0_wc_underflow", wc(0), 11'd0);

    // ch5: fill to full, then one refused write
    write_enable[5] = 1'b1;
    for (int n = 1; n <= 1025; n++) begin
      set_din(5, 16'(n));
      tick();
      if (n == 1019 || n == 1020) check($sformatf("ch5_af_w%0d", n), almost_full_flag[5], (n >= 1020));
      if (n == 1023 || n == 1024) check($sformatf("ch5_full_w%0d", n), full_flag[5], (n >= 1024));
    end
    write_enable[5] = 1'b0;
    check("ch5_wc_overflow", wc(5), 11'd1024);
    check("ch5_rc_full", rc(5), 12'd2048);
    check("ch5_full_hold", full_flag[5], 1'b1);
`ifdef FIFO_HUB_ERR_FLAGS_EN
    check("ch5_err", error_flag[5], 1'b1);
`endif
    read_enable[5] = 1'b1;
    tick();
    check("ch5_head_hi", dq(5), 8'h00);
    tick();
    check("ch5_head_lo", dq(5), 8'h01);
    read_enable[5] = 1'b0;
    check("ch5_wc_after_pop", wc(5), 11'd1023);

    // ch3: two full fill/drain passes across the pointer wrap
    for (int p = 0; p < 2; p++) begin
      write_enable[3] = 1'b1;
      for (int i = 0; i < 1024; i++) begin
        set_din(3, 16'(p * 1024 + i));
        tick();
      end
      write_enable[3] = 1'b0;
      check($sformatf("ch3_full_p%0d", p), full_flag[3], 1'b1);
      read_enable[3] = 1'b1;
      for (int j = 0; j < 2048; j++) begin
        tick();
        w = 16'(p * 1024 + j / 2);
        exp_slice = (j % 2 == 0) ? w[15:8] : w[7:0];
        check($sformatf("ch3_p%0d_s%0d", p, j), dq(3), exp_slice);
      end
      read_enable[3] = 1'b0;
      check($sformatf("ch3_empty_p%0d", p), empty_flag[3], 1'b1);
      check($sformatf("ch3_wc_p%0d", p), wc(3), 11'd0);
    end

    // ch2: read every cycle, write every other cycle, starting empty
    read_enable[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      write_enable[2] = (i % 2 == 0);
      set_din(2, 16'hA000 + 16'(i / 2));
      tick();
      check($sformatf("ch2_wc_c%0d", i), wc(2), 11'd1);
      if (i >= 1) begin
        w = 16'hA000 + 16'((i - 1) / 2 / 1);
        w = 16'hA000 + 16'(((i - 1) / 2));
        exp_slice = ((i - 1) % 2 == 0) ? w[15:8] : w[7:0];
        check($sformatf("ch2_dout_c%0d", i), dq(2), exp_slice);
      end
    end
    read_enable[2]  = 1'b0;
    write_enable[2] = 1'b0;
`ifdef FIFO_HUB_ERR_FLAGS_EN
    check("err_vector", error_flag, 8'b0010_0101);
`endif

    // asynchronous reset in the middle of a burst on every channel
    write_enable = 8'hFF;
    for (int i = 0; i < 50; i++) begin
      for (int c = 0; c < CH; c++) set_din(c, 16'(c * 256 + i));
      tick();
      if (i == 25) begin
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr_count", wr_count, '0);
        check("mid_rst_rd_count", rd_count, '0);
        check("mid_rst_empty", empty_flag, 8'hFF);
        check("mid_rst_full", full_flag, 8'h00);
        check("mid_rst_dout", dout, '0);
`ifdef FIFO_HUB_ERR_FLAGS_EN
        check("mid_rst_err", error_flag, 8'h00);
`endif
        break;
      end
    end
    write_enable = '0;
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_wr_count", wr_count, '0);

    set_din(7, 16'hBEEF);
    write_enable[7] = 1'b1;
    tick();
    write_enable[7] = 1'b0;
    read_enable[7]  = 1'b1;
    tick();
    read_enable[7]  = 1'b0;
    check("ch7_after_rst", dq(7), 8'hBE);
    check("ch7_rc_after_rst", rc(7), 12'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
